// File: rtl/uart_rx_r0_pkg.sv
// Shared UART definitions: FSM state encodings for the receiver and transmitter,
// default start-bit level and a constant-evaluable ceil-log2 helper.
package uart_rx_r0_pkg;

  localparam logic DEF_START_BIT = 1'b0;

  typedef enum logic [1:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_r0_sync.sv
// Multi-flop input synchronizer with a configurable reset level, so the
// synchronized line can come out of reset already at its idle value.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_r0.sv
// UART receiver: start bit, BIT_WIDTH data bits MSB first, one stop bit.
// Emits a one-cycle valid pulse per good word and a frameErr pulse on a bad stop bit.
module uart_rx_r0
  import uart_rx_r0_pkg::*;
#(
  parameter int unsigned BIT_WIDTH    = 8,
  parameter logic        START_BIT    = DEF_START_BIT,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [BIT_WIDTH-1:0] dataOut,
  output logic                 valid,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int unsigned H  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CW = (clog2(CLKS_PER_BIT) == 0) ? 1 : clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_LAST   = (H > 0) ? CW'(H - 1) : '0;
  localparam logic [3:0]    BIT_LAST = 4'(BIT_WIDTH - 1);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [CW-1:0]        r_clk_cnt;
  logic [3:0]           r_bit_cnt;
  logic [BIT_WIDTH-1:0] r_shreg;
  logic [BIT_WIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  logic w_rx_s;
  logic w_tick;
  logic w_h_tick;
  logic w_shift;
  logic w_valid_nxt;
  logic w_ferr_nxt;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(~START_BIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(rx),
    .o_q(w_rx_s)
  );

  assign w_tick   = (r_clk_cnt == CNT_LAST);
  assign w_h_tick = (r_clk_cnt == H_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= s_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // With H==0 the mid-bit point of the start bit is c0 itself, so START is skipped.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      s_IDLE: begin
        if (w_rx_s == START_BIT) begin
          w_state_nxt = (H > 0) ? s_START : s_DATA;
        end
      end
      s_START: begin
        if (w_h_tick) begin
          w_state_nxt = (w_rx_s == START_BIT) ? s_DATA : s_IDLE;
        end
      end
      s_DATA: begin
        if (w_tick && (r_bit_cnt == BIT_LAST)) begin
          w_state_nxt = s_STOP;
        end
      end
      s_STOP: begin
        if (w_tick) begin
          w_state_nxt = s_IDLE;
        end
      end
      default: w_state_nxt = s_IDLE;
    endcase
  end

  always_comb begin
    w_shift     = 1'b0;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      s_DATA: w_shift = w_tick;
      s_STOP: begin
        w_valid_nxt = w_tick && (w_rx_s != START_BIT);
        w_ferr_nxt  = w_tick && (w_rx_s == START_BIT);
      end
      default: ;
    endcase
  end

  // Clock counter restarts on every state change and on every bit-period tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      r_busy      <= (w_state_nxt != s_IDLE);

      if ((r_state == s_IDLE) || (w_state_nxt != r_state) || w_tick) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end

      if (r_state != s_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_tick) begin
        r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 4'd1;
      end

      if (w_shift) begin
        r_shreg <= {r_shreg[BIT_WIDTH-2:0], w_rx_s};
      end

      if (w_valid_nxt) begin
        r_data <= r_shreg;
      end
    end
  end

  assign dataOut  = r_data;
  assign valid    = r_valid;
  assign frameErr = r_frame_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_r0.sv
// Bench for uart_rx_r0: a 16-clock/bit receiver and a 1-clock/bit (loopback-rate) receiver,
// driven with directed and random frames; expected events are scheduled from frame timing rules.
module tb_uart_rx_r0;

  localparam int unsigned BW   = 8;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic [7:0] dout0, dout1;
  logic       v0, v1, fe0, fe1, b0, b1;

  always #5 clk = ~clk;

  uart_rx_r0 #(
    .BIT_WIDTH   (BW),
    .START_BIT   (1'b0),
    .CLKS_PER_BIT(16),
    .SYNC_STAGES (SYNC)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx0),
    .dataOut (dout0),
    .valid   (v0),
    .frameErr(fe0),
    .busy    (b0)
  );

  uart_rx_r0 #(
    .BIT_WIDTH   (BW),
    .START_BIT   (1'b0),
    .CLKS_PER_BIT(1),
    .SYNC_STAGES (SYNC)
  ) u_dut_lb (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx1),
    .dataOut (dout1),
    .valid   (v1),
    .frameErr(fe1),
    .busy    (b1)
  );

  typedef enum int {K_VALID, K_FERR, K_BUSY, K_DATA} kind_t;
  typedef struct {
    longint     t;
    kind_t      k;
    logic [7:0] v;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  longint     cyc     = 0;
  exp_t       exp_q[2][$];
  logic [7:0] ref_data[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, req, cyc);
    end
  endtask

  function automatic int unsigned cpb(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  task automatic expect_at(input int d, input longint t, input kind_t k, input logic [7:0] v);
    exp_t e;
    e.t = t;
    e.k = k;
    e.v = v;
    exp_q[d].push_back(e);
  endtask

  task automatic monitor(input int d, input logic v, input logic fe, input logic b,
                         input logic [7:0] dout);
    exp_t e;
    bit   exp_v;
    bit   exp_fe;
    exp_v  = 0;
    exp_fe = 0;
    while (exp_q[d].size() > 0 && exp_q[d][0].t <= cyc) begin
      e = exp_q[d].pop_front();
      if (e.t < cyc) check($sformatf("slot_missed%0d", d), cyc, e.t);
      case (e.k)
        K_VALID: begin exp_v  = 1; check($sformatf("valid%0d", d), v, 1); end
        K_FERR:  begin exp_fe = 1; check($sformatf("frameErr%0d", d), fe, 1); end
        K_BUSY:  check($sformatf("busy%0d", d), b, e.v[0]);
        default: check($sformatf("dataOut%0d", d), dout, e.v);
      endcase
    end
    if (v && !exp_v) check($sformatf("spurious_valid%0d", d), v, 0);
    if (fe && !exp_fe) check($sformatf("spurious_frameErr%0d", d), fe, 0);
    if (v || fe) check($sformatf("valid_and_frameErr%0d", d), v & fe, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor(0, v0, fe0, b0, dout0);
      monitor(1, v1, fe1, b1, dout1);
    end
  end

  // Called and returns at posedge+1; holds the line level for n cycles.
  task automatic line(input int d, input logic lvl, input int unsigned n);
    if (d == 0) rx0 = lvl;
    else        rx1 = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A bad stop bit is held low only through its sample point, so the receiver
  // does not mistake the remainder of it for a fresh start bit.
  task automatic send_frame(input int d, input logic [7:0] data, input bit good_stop,
                            input int unsigned gap);
    int unsigned c;
    int unsigned h;
    longint      c0;
    longint      stop_t;
    logic [7:0]  old;
    c      = cpb(d);
    h      = (c - 1) / 2;
    c0     = cyc + SYNC;
    stop_t = c0 + h + (BW + 1) * c;
    old    = ref_data[d];
    if (good_stop) ref_data[d] = data;
    expect_at(d, c0,         K_BUSY, 8'd0);
    expect_at(d, c0 + 1,     K_BUSY, 8'd1);
    expect_at(d, c0 + 1,     K_DATA, old);
    expect_at(d, stop_t,     K_BUSY, 8'd1);
    expect_at(d, stop_t + 1, good_stop ? K_VALID : K_FERR, 8'd0);
    expect_at(d, stop_t + 1, K_BUSY, 8'd0);
    expect_at(d, stop_t + 1, K_DATA, ref_data[d]);
    line(d, 1'b0, c);
    for (int i = BW - 1; i >= 0; i--) line(d, data[i], c);
    if (good_stop) begin
      line(d, 1'b1, c);
    end else begin
      line(d, 1'b0, h + 1);
      line(d, 1'b1, c - h - 1);
    end
    line(d, 1'b1, gap);
  endtask

  task automatic glitch(input int unsigned len);
    int unsigned h;
    longint      c0;
    h  = (cpb(0) - 1) / 2;
    c0 = cyc + SYNC;
    expect_at(0, c0 + 1, K_BUSY, 8'd1);
    expect_at(0, c0 + h, K_BUSY, 8'd1);
    expect_at(0, c0 + h + 1, K_BUSY, 8'd0);
    line(0, 1'b0, len);
    line(0, 1'b1, h + SYNC + 4);
  endtask

  initial begin
    logic [7:0] partial;
    int unsigned r;
    rst         = 1'b1;
    rx0         = 1'b1;
    rx1         = 1'b1;
    ref_data[0] = 8'h00;
    ref_data[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataOut0", dout0, 0);
    check("rst_valid0", v0, 0);
    check("rst_frameErr0", fe0, 0);
    check("rst_busy0", b0, 0);
    check("rst_dataOut1", dout1, 0);
    check("rst_busy1", b1, 0);
    rst = 1'b0;
    line(0, 1'b1, 5);

    send_frame(0, 8'hA5, 1, 10);
    glitch(4);
    send_frame(0, 8'h3C, 0, 10);
    send_frame(0, 8'h00, 1, 0);
    send_frame(0, 8'hFF, 1, 6);

    // Abort a frame partway through data bit 3.
    partial = 8'hC3;
    line(0, 1'b0, 16);
    for (int i = 7; i >= 5; i--) line(0, partial[i], 16);
    line(0, partial[4], 8);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dataOut0", dout0, 0);
    check("async_rst_busy0", b0, 0);
    check("async_rst_valid0", v0, 0);
    check("async_rst_frameErr0", fe0, 0);
    exp_q[0].delete();
    exp_q[1].delete();
    ref_data[0] = 8'h00;
    ref_data[1] = 8'h00;
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    line(0, 1'b1, 5);
    send_frame(0, 8'h5A, 1, 4);

    send_frame(1, 8'h81, 1, 0);
    send_frame(1, 8'h7E, 1, 3);

    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) glitch($urandom_range(1, 7));
      else       send_frame(0, 8'($urandom), r != 2, $urandom_range(0, 12));
    end
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      send_frame(1, 8'($urandom), r != 0, $urandom_range(0, 3));
    end

    for (int i = 0; i < 2000 && (exp_q[0].size() > 0 || exp_q[1].size() > 0); i++) begin
      @(posedge clk);
    end
    #1;
    check("pending0", exp_q[0].size(), 0);
    check("pending1", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_r0.md
# uart_rx_r0

Serial receiver that is the receive-side partner of the UART transmitter. It deserializes the transmitter's frame format from the `rx` line into parallel words: one start bit (`START_BIT`), `BIT_WIDTH` data bits MSB first, and one stop bit (`~START_BIT`). Each accepted word is presented with a single-cycle `valid` pulse. It sits between the pad/loopback line and downstream consumers such as a FIFO or command decoder. It also flags framing errors.

## Interface
Parameters:
- `BIT_WIDTH`, 8: data bits per frame; legal range 5..14.
- `START_BIT`, 0: start-bit level. Idle and stop level is `~START_BIT`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 1..1024. A value of 1 matches the transmitter's one-bit-per-clock output.
- `SYNC_STAGES`, 2: number of input synchronizer flops; legal range 1..3.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `rx`, input, 1: serial line.
- `dataOut`, output, `BIT_WIDTH`: last correctly framed word, held until the next good frame.
- `valid`, output, 1: one-cycle pulse; `dataOut` is new in that cycle.
- `frameErr`, output, 1: one-cycle pulse when the stop bit is bad.
- `busy`, output, 1: high while a frame is in progress (state is not IDLE).

## Operation
- `rx` passes through `SYNC_STAGES` flops to form `rx_s`. The synchronizer flops reset to `~START_BIT` so that reset release never looks like a start bit.
- Define `H = (CLKS_PER_BIT-1)/2` using integer division. Sampling points fall at the middle of each bit.
- The FSM has four states: IDLE, START, DATA, STOP. It uses a clock counter of clog2(`CLKS_PER_BIT`) bits (minimum 1) and a bit counter of 4 bits.
- IDLE:
  - If `rx_s == START_BIT` (level-detected), record this cycle as c0.
  - If H>0, go to START with the clock counter cleared.
  - If H==0, go directly to DATA.
- START: count to H, then re-sample.
  - `rx_s == START_BIT`: go to DATA.
  - Otherwise the start was a glitch. Return to IDLE with no pulse.
- DATA:
  - Sample every `CLKS_PER_BIT` cycles.
  - Shift left into the shift register: `shreg <= {shreg[BIT_WIDTH-2:0], rx_s}`. The first sampled bit becomes the MSB.
  - After `BIT_WIDTH` samples, go to STOP.
- STOP: sample once, `CLKS_PER_BIT` cycles after the last data sample.
  - `rx_s == ~START_BIT`: load `dataOut <= shreg` and pulse `valid`.
  - Otherwise pulse `frameErr` and leave `dataOut` unchanged.
  - In both cases go to IDLE. The FSM does not wait for the stop bit to end, so a start bit in the next cycle is accepted.
- `valid` and `frameErr` are never high in the same cycle.
- Reset values: `dataOut=0`, `valid=0`, `frameErr=0`, `busy=0`, state IDLE, all counters 0.
- Reset mid-frame: asserting `rst` aborts the frame immediately (asynchronous) and produces no pulse. The first frame after reset release is received normally.

## Timing
- `rx_s` lags `rx` by `SYNC_STAGES` cycles. All cycle counts below are relative to c0, the IDLE cycle that sees `rx_s == START_BIT`.
- Start re-check: c0+H.
- Data bit k (k=0 is the MSB): sampled at c0+H+(k+1)·`CLKS_PER_BIT`.
- Stop sample: c0+H+(`BIT_WIDTH`+1)·`CLKS_PER_BIT`.
- `valid` or `frameErr` is high exactly in the cycle after the stop sample. `dataOut` updates in that same cycle.
- `busy` is registered. It is high from c0+1 through the stop-sample cycle and low in the pulse cycle.
- Back-to-back frames: the earliest next c0 is the cycle after the stop sample.
- There is no back-pressure. The consumer must capture `dataOut` on `valid`. A later good frame overwrites it.

## Structure
- Shared header `uart_defs.vh` (package equivalent) holds:
  - the state encodings `s_IDLE`, `s_START`, `s_DATA`, `s_STOP`;
  - the default `START_BIT`;
  - a `clog2` function.
  - The transmitter's encodings are moved into this header as well.
- Sub-module `uart_sync`: a `SYNC_STAGES`-deep synchronizer with a reset value parameter. It is instantiated once.
- All remaining logic stays in `uart_rx_r0`: FSM, counters and shift register.

## Test plan
- Good frame, `CLKS_PER_BIT`=16, `BIT_WIDTH`=8: drive the line sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles long. Required: `dataOut=0xA5`, `valid` high only at c0+152, `frameErr` stays 0.
- Glitch rejection: drive `rx` low for 4 cycles, then high. Required: no `valid` and no `frameErr`; `busy` high from c0+1 through c0+7, and low from c0+8.
- Framing error: send 0x3C with the stop bit driven 0 after a prior good 0xA5. Required: one `frameErr` pulse, `dataOut` stays 0xA5, no `valid`.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap. Required: two `valid` pulses exactly 160 cycles apart, carrying 0x00 then 0xFF.
- Reset mid-frame: assert `rst` during data bit 3, then release, then send 0x5A. Required:
  - all outputs go to 0 asynchronously and no pulse is produced for the aborted frame;
  - 0x5A is then received with `valid`.
- Loopback, `CLKS_PER_BIT`=1: connect the transmitter's `dataOut` to `rx` and pulse its `tx` input with `dataIn`=0x81, then 0x7E. Required: `valid` pulses with `dataOut` 0x81, then 0x7E, and `frameErr` stays 0.
